// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: turns one (origin, size, colour) command into a raster-order
// stream of clipped frame-buffer writes, one per clock, followed by a done pulse.
module rect_fill_engine #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int COORD_W  = 8,
    parameter int COLOR_W  = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_w,
    input  logic [COORD_W-1:0] cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COLOR_W-1:0] color,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    localparam logic [COORD_W:0] LIM_W = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0] LIM_H = (COORD_W+1)'(SCREEN_H);

    // Last covered coordinate, saturated at the screen edge; one extra bit keeps
    // org+len from wrapping back to column/row 0.
    function automatic logic [COORD_W-1:0] clip_last(
        input logic [COORD_W-1:0] org,
        input logic [COORD_W-1:0] len,
        input logic [COORD_W:0]   lim
    );
        logic [COORD_W:0] e;
        e = {1'b0, org} + {1'b0, len};
        if (e > lim) e = lim;
        e = e - (COORD_W+1)'(1);
        return e[COORD_W-1:0];
    endfunction

    state_t               r_state, w_state;
    logic [COORD_W-1:0]   r_x, w_x, r_y, w_y;
    logic [COLOR_W-1:0]   r_color, w_color;
    logic                 r_plot, w_plot, r_busy, w_busy, r_done, w_done, r_ready, w_ready;
    logic [COORD_W-1:0]   r_x0, w_x0, r_x_last, w_x_last, r_y_last, w_y_last;
    logic                 w_empty;

    assign w_empty = (cmd_w == '0) || (cmd_h == '0) ||
                     ({1'b0, cmd_x0} >= LIM_W) || ({1'b0, cmd_y0} >= LIM_H);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
            r_plot  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state;
            r_x     <= w_x;
            r_y     <= w_y;
            r_color <= w_color;
            r_plot  <= w_plot;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_ready <= w_ready;
        end
    end

    // Rectangle bounds are only meaningful while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        r_x0     <= w_x0;
        r_x_last <= w_x_last;
        r_y_last <= w_y_last;
    end

    always_comb begin
        w_state  = r_state;
        w_x      = r_x;
        w_y      = r_y;
        w_color  = r_color;
        w_plot   = 1'b0;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_ready  = r_ready;
        w_x0     = r_x0;
        w_x_last = r_x_last;
        w_y_last = r_y_last;
        case (r_state)
            S_IDLE: begin
                w_busy  = 1'b0;
                w_ready = 1'b1;
                if (cmd_valid) begin
                    w_x0     = cmd_x0;
                    w_x_last = clip_last(cmd_x0, cmd_w, LIM_W);
                    w_y_last = clip_last(cmd_y0, cmd_h, LIM_H);
                    w_color  = cmd_color;
                    w_ready  = 1'b0;
                    w_busy   = 1'b1;
                    if (w_empty) begin
                        w_state = S_DONE;
                        w_done  = 1'b1;
                    end else begin
                        w_state = S_DRAW;
                        w_x     = cmd_x0;
                        w_y     = cmd_y0;
                        w_plot  = 1'b1;
                    end
                end
            end
            S_DRAW: begin
                w_plot = 1'b1;
                if (r_x < r_x_last) begin
                    w_x = r_x + COORD_W'(1);
                end else if (r_y < r_y_last) begin
                    w_x = r_x0;
                    w_y = r_y + COORD_W'(1);
                end else begin
                    w_state = S_DONE;
                    w_plot  = 1'b0;
                    w_done  = 1'b1;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_ready = 1'b1;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
                w_ready = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign x         = r_x;
    assign y         = r_y;
    assign color     = r_color;
    assign plot      = r_plot;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cmd_ready = r_ready;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: expected pixels are queued when a command is
// driven and popped against every plot cycle; timing and flags are checked in line.
module tb_rect_fill_engine;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x0, cmd_y0, cmd_w, cmd_h;
    logic [2:0] cmd_color;
    logic [7:0] x, y;
    logic [2:0] color;
    logic       plot, busy, done;

    rect_fill_engine dut (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .x(x), .y(y), .color(color),
        .plot(plot), .busy(busy), .done(done)
    );

    always #10 clk = ~clk;

    logic [18:0] sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_plot_cyc = -1;
    int gap = 0;
    int guard;
    int saved_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (plot === 1'b1) begin
            if (sb.size() == 0) chk("plot_unexpected", {31'd0, plot}, 32'd0);
            else chk("pixel_xyc", {13'd0, x, y, color}, {13'd0, sb.pop_front()});
            if (last_plot_cyc >= 0 && cyc - last_plot_cyc > 1) gap = cyc - last_plot_cyc;
            last_plot_cyc = cyc;
        end
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic push_rect(input int x0, input int y0, input int w, input int h,
                             input int c, output int n);
        int xe, ye;
        xe = (x0 + w > 160) ? 160 : x0 + w;
        ye = (y0 + h > 120) ? 120 : y0 + h;
        n = 0;
        for (int yy = y0; yy < ye; yy++)
            for (int xx = x0; xx < xe; xx++) begin
                sb.push_back({8'(xx), 8'(yy), 3'(c)});
                n++;
            end
    endtask

    task automatic drive(input int x0, input int y0, input int w, input int h, input int c);
        cmd_x0    = 8'(x0);
        cmd_y0    = 8'(y0);
        cmd_w     = 8'(w);
        cmd_h     = 8'(h);
        cmd_color = 3'(c);
    endtask

    task automatic run_cmd(input string tag, input int x0, input int y0, input int w,
                           input int h, input int c);
        int n, g;
        push_rect(x0, y0, w, h, c, n);
        drive(x0, y0, w, h, c);
        cmd_valid = 1'b1;
        g = 0;
        while (cmd_ready !== 1'b1 && g < 20) begin tick(); g++; end
        chk({tag, "_ready_before"}, {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_plot"}, {31'd0, plot}, 32'd1);
            chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
            tick();
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_plot_at_done"}, {31'd0, plot}, 32'd0);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, "_sb_left"}, sb.size(), 32'd0);
    endtask

    initial begin
        int n;
        // Reset held two edges with a command pending.
        resetn = 1'b0;
        drive(1, 1, 2, 2, 5);
        cmd_valid = 1'b1;
        tick();
        tick();
        chk("rst_plot", {31'd0, plot}, 32'd0);
        chk("rst_x", {24'd0, x}, 32'd0);
        chk("rst_y", {24'd0, y}, 32'd0);
        chk("rst_color", {29'd0, color}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        resetn = 1'b1;
        cmd_valid = 1'b0;
        tick();
        chk("rst_nothing_accepted", {31'd0, busy}, 32'd0);

        run_cmd("basic", 10, 20, 3, 2, 4);
        run_cmd("clip_corner", 158, 119, 5, 4, 1);
        run_cmd("clip_far", 250, 10, 200, 1, 2);
        run_cmd("clip_wide", 100, 3, 200, 1, 3);
        run_cmd("empty_w", 5, 5, 0, 3, 6);
        run_cmd("empty_h", 5, 5, 3, 0, 6);
        run_cmd("empty_x", 160, 5, 3, 3, 6);
        run_cmd("empty_y", 5, 120, 3, 3, 6);

        // Command held valid and changed mid-draw; the next one follows after two idle cycles.
        last_plot_cyc = -1;
        gap = 0;
        push_rect(5, 5, 4, 2, 3, n);
        drive(5, 5, 4, 2, 3);
        cmd_valid = 1'b1;
        tick();
        chk("hs_first_plot", {31'd0, plot}, 32'd1);
        push_rect(50, 60, 2, 2, 6, n);
        drive(50, 60, 2, 2, 6);
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 40) begin tick(); guard++; end
        chk("hs_ready_seen", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("hs_second_plot", {31'd0, plot}, 32'd1);
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin tick(); guard++; end
        chk("hs_done_seen", {31'd0, done}, 32'd1);
        chk("hs_gap", gap, 32'd3);
        chk("hs_sb_left", sb.size(), 32'd0);
        tick();

        // Reset while the 5th pixel of a 10x10 fill is on the outputs.
        push_rect(0, 0, 10, 1, 5, n);
        while (sb.size() > 5) void'(sb.pop_back());
        drive(0, 0, 10, 10, 5);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_5th_x", {24'd0, x}, 32'd4);
        saved_done = done_cnt;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("mid_plot", {31'd0, plot}, 32'd0);
        chk("mid_x", {24'd0, x}, 32'd0);
        chk("mid_y", {24'd0, y}, 32'd0);
        chk("mid_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        chk("mid_no_done", done_cnt, saved_done);
        chk("mid_sb_left", sb.size(), 32'd0);
        run_cmd("after_rst", 5, 5, 1, 1, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Pixel generator that sits directly upstream of the 160x120 3-bit-colour VGA frame-buffer adapter, inside the system datapath.
- Accepts one rectangle command at a time (origin, size, colour) over a valid/ready handshake.
- Emits one frame-buffer write per clock as x/y/colour/plot in raster order, clipped to the screen, then pulses done.
- Used for screen clears, paddles, blocks and sprites without per-pixel control from the main FSM.

Parameters:
- SCREEN_W, 160, visible width in pixels; x >= SCREEN_W is never plotted.
- SCREEN_H, 120, visible height in pixels; y >= SCREEN_H is never plotted.
- COORD_W, 8, width of all coordinate and size fields.
- COLOR_W, 3, colour width (1 bit per RGB channel).

Ports:
- clk  in  1  system clock, 50 MHz.
- resetn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  engine is idle and can accept a command.
- cmd_x0  in  COORD_W  left column.
- cmd_y0  in  COORD_W  top row.
- cmd_w  in  COORD_W  width in pixels; 0 means empty.
- cmd_h  in  COORD_W  height in pixels; 0 means empty.
- cmd_color  in  COLOR_W  fill colour.
- x  out  COORD_W  pixel column to the adapter.
- y  out  COORD_W  pixel row to the adapter.
- color  out  COLOR_W  pixel colour to the adapter.
- plot  out  1  write strobe: x/y/color are valid this cycle.
- busy  out  1  a command is in progress (DRAW or DONE).
- done  out  1  single-cycle pulse after the last pixel, or after an empty command.

Behaviour:
- All outputs are registered; the only state change on an edge without resetn is the normal FSM step.
- Reset: sampled on the rising clk edge while resetn=0. Next values: state=IDLE, x=0, y=0, color=0, plot=0, busy=0, done=0, cmd_ready=1. Reset overrides any in-progress command.
- FSM states: IDLE, DRAW, DONE.
- IDLE: cmd_ready=1, plot=0. On an edge with cmd_valid=1 (accept edge T), latch x0, y0 and cmd_color, and compute clipped extents using COORD_W+1-bit arithmetic:
  - x_last = min(x0+w, SCREEN_W) - 1
  - y_last = min(y0+h, SCREEN_H) - 1
  - Empty command (w=0, h=0, x0>=SCREEN_W or y0>=SCREEN_H): go to DONE.
  - Otherwise: go to DRAW with x=x0, y=y0, plot=1.
  - cmd_ready falls to 0 after T.
- DRAW: plot=1 every cycle, color = latched colour. Each edge:
  - x<x_last: x++.
  - x=x_last and y<y_last: x=x0, y++.
  - x=x_last and y=y_last: go to DONE.
- Latency: the first pixel is visible in cycle T+1. The number of plot cycles is exactly clipped_w*clipped_h, with no gaps.
- DONE: lasts one cycle. plot=0, done=1, busy=1, and x/y hold the last values. Next edge goes to IDLE (cmd_ready=1, done=0, busy=0).
- Command inputs are ignored outside IDLE. A command held asserted is accepted on the first IDLE edge, so back-to-back commands have exactly 2 non-plot cycles (DONE, IDLE) between them.
- Never outputs plot=1 with x>=SCREEN_W or y>=SCREEN_H.
- x0+w overflow beyond 2^COORD_W is handled by the wider arithmetic; no wrap-around to column 0.
- busy=1 in DRAW and DONE.

Test Plan:
1. Reset: hold resetn=0 for 2 edges with cmd_valid=1 -> plot=0, x=0, y=0, color=0, done=0, busy=0, cmd_ready=1, and nothing is accepted while resetn=0.
2. Basic fill: accept x0=10, y0=20, w=3, h=2, color=4 at edge T -> plot=1 for cycles T+1..T+6 at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), color=4. done=1 only at T+7; cmd_ready=1 from T+8.
3. Clipping: x0=158, y0=119, w=5, h=4 -> exactly 2 plots at (158,119),(159,119), done at T+3. A separate run with x0=250, w=200 (sum overflows 8 bits) -> no plot, done at T+1.
4. Empty commands: w=0; then h=0; then x0=160; then y0=120 -> each gives zero plot cycles, done at T+1, cmd_ready at T+2.
5. Handshake: keep cmd_valid=1 and change cmd_color and cmd_x0 mid-draw -> the active rectangle is unaffected. The next command is accepted at the first IDLE edge, and its first pixel appears exactly 3 cycles after the previous last pixel.
6. Reset mid-operation: 10x10 fill at (0,0), drop resetn for one edge at the 5th pixel -> next cycle plot=0, x=0, y=0, cmd_ready=1, no done pulse. A following 1x1 command at (5,5) plots exactly one pixel.
